// File: rtl/life_pkg.sv
// Shared types and helpers for the 8x8 Game of Life controller.
// The halt classifier lives here so the priority order is defined in one place.
package life_pkg;

  localparam int GRID_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PAUSE = 2'b01,
    RUN   = 2'b10,
    HALT  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    EXTINCT = 2'b01,
    STILL   = 2'b10,
    OSC2    = 2'b11
  } halt_cause_t;

  // Extinction beats still life, which beats period-2.
  function automatic halt_cause_t halt_check(
    input logic [GRID_W-1:0] evo,
    input logic [GRID_W-1:0] cur,
    input logic [GRID_W-1:0] prev,
    input logic              prev_valid
  );
    if (evo == '0) return EXTINCT;
    if (evo == cur) return STILL;
    if (prev_valid && (evo == prev)) return OSC2;
    return NONE;
  endfunction

endpackage

// File: rtl/datapath.sv
// Combinational Game of Life evolve step for an 8x8 grid with dead borders.
// Bit index = row*8 + col.
module datapath
  import life_pkg::*;
(
  input  logic [GRID_W-1:0] grid_in,
  output logic [GRID_W-1:0] grid_out
);

  // Grid surrounded by a ring of permanently dead cells.
  logic [9:0] w_pad [10];

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_pad
      if (gi == 0 || gi == 9) begin : g_edge
        assign w_pad[gi] = '0;
      end else begin : g_row
        assign w_pad[gi] = {1'b0, grid_in[(gi-1)*8 +: 8], 1'b0};
      end
    end

    for (gi = 0; gi < GRID_W; gi++) begin : g_cell
      localparam int R = gi / 8 + 1;
      localparam int C = gi % 8 + 1;
      logic [3:0] w_n;
      assign w_n = {3'b000, w_pad[R-1][C-1]} + {3'b000, w_pad[R-1][C]}
                 + {3'b000, w_pad[R-1][C+1]} + {3'b000, w_pad[R][C-1]}
                 + {3'b000, w_pad[R][C+1]}   + {3'b000, w_pad[R+1][C-1]}
                 + {3'b000, w_pad[R+1][C]}   + {3'b000, w_pad[R+1][C+1]};
      assign grid_out[gi] = (w_n == 4'd3) | (w_pad[R][C] & (w_n == 4'd2));
    end
  endgenerate

endmodule

// File: rtl/tick_prescaler.sv
// Generation-rate prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count, so one tick arrives every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic flopreset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  assign tick = enable && (r_count == TERM);

  always_ff @(posedge clk or negedge flopreset) begin
    if (!flopreset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == TERM) ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/life_ctrl.sv
// Generation controller: owns the grid, sequences evolution (free-run or
// single-step), counts generations and halts on extinction/still/period-2.
module life_ctrl
  import life_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int GEN_W    = 16
) (
  input  logic              clk,
  input  logic              flopreset,
  input  logic              start,
  input  logic              run,
  input  logic              step,
  input  logic [GRID_W-1:0] shift_seed,
  input  logic [GRID_W-1:0] grid_evo,
  output logic [GRID_W-1:0] gridOut,
  output logic [GEN_W-1:0]  gen_count,
  output logic              running,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic              evolve
);

  state_t            r_state;
  state_t            w_state_next;
  logic [GRID_W-1:0] r_grid;
  logic [GRID_W-1:0] r_grid_prev;
  logic              r_prev_valid;
  logic [GEN_W-1:0]  r_gen;
  halt_cause_t       r_cause;
  halt_cause_t       w_cause;
  logic              r_evolve;
  logic              r_start_d;
  logic              r_step_d;
  logic              r_armed;

  logic w_start_rise;
  logic w_step_rise;
  logic w_tick;
  logic w_load;
  logic w_do_evolve;
  logic w_presc_clear;
  logic w_presc_en;

  // r_armed masks the first cycle after reset, so a level already high
  // through reset release is not mistaken for a fresh rise.
  assign w_start_rise = start & ~r_start_d & r_armed;
  assign w_step_rise  = step  & ~r_step_d  & r_armed;
  assign w_presc_en   = (r_state == RUN);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk       (clk),
    .flopreset (flopreset),
    .clear     (w_presc_clear),
    .enable    (w_presc_en),
    .tick      (w_tick)
  );

  always_ff @(posedge clk or negedge flopreset) begin
    if (!flopreset) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_do_evolve   = 1'b0;
    w_presc_clear = 1'b0;
    w_cause       = halt_check(grid_evo, r_grid, r_grid_prev, r_prev_valid);
    if (w_start_rise) begin
      w_load        = 1'b1;
      w_presc_clear = 1'b1;
      w_state_next  = run ? RUN : PAUSE;
    end else begin
      case (r_state)
        PAUSE: begin
          w_do_evolve = w_step_rise;
          if (run) begin
            w_state_next  = RUN;
            w_presc_clear = 1'b1;
          end
        end
        RUN: begin
          w_do_evolve = w_tick;
          if (!run) w_state_next = PAUSE;
        end
        default: w_state_next = r_state;
      endcase
      if (w_do_evolve && (w_cause != NONE)) w_state_next = HALT;
    end
  end

  always_ff @(posedge clk or negedge flopreset) begin
    if (!flopreset) begin
      r_grid       <= '0;
      r_grid_prev  <= '0;
      r_prev_valid <= 1'b0;
      r_gen        <= '0;
      r_cause      <= NONE;
      r_evolve     <= 1'b0;
      r_start_d    <= 1'b0;
      r_step_d     <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_start_d <= start;
      r_step_d  <= step;
      r_armed   <= 1'b1;
      r_evolve  <= w_do_evolve;
      if (w_load) begin
        r_grid       <= shift_seed;
        r_gen        <= '0;
        r_cause      <= NONE;
        r_prev_valid <= 1'b0;
      end else if (w_do_evolve) begin
        r_grid_prev  <= r_grid;
        r_grid       <= grid_evo;
        r_prev_valid <= 1'b1;
        r_cause      <= w_cause;
        if (r_gen != '1) r_gen <= r_gen + GEN_W'(1);
      end
    end
  end

  assign gridOut    = r_grid;
  assign gen_count  = r_gen;
  assign running    = (r_state == RUN);
  assign halted     = (r_state == HALT);
  assign halt_cause = r_cause;
  assign evolve     = r_evolve;

endmodule

// File: tb/tb_life_ctrl.sv
// Directed bench for life_ctrl: vector table for single-step scenarios, plus
// hand-written sequences for RUN cadence, load priority and async reset.
module tb_life_ctrl;

  localparam logic [63:0] BLINKER = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] VERT    = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;
  localparam logic [63:0] GLIDER  = 64'h0000_0000_0E08_0400;
  localparam logic [63:0] GLIDER4 = 64'h0000_001C_1008_0000;

  logic        clk;
  logic        flopreset;
  logic        start;
  logic        run;
  logic        step;
  logic [63:0] seed;

  logic [63:0] a_grid, a_evo, b_grid, b_evo;
  logic [15:0] a_gen, b_gen;
  logic        a_running, a_halted, a_evolve, b_running, b_halted, b_evolve;
  logic [1:0]  a_cause, b_cause;

  int n_pass;
  int n_total;

  typedef struct {
    logic        start;
    logic        run;
    logic        step;
    logic [63:0] seed;
    logic [63:0] grid;
    logic [15:0] gen;
    logic        running;
    logic        halted;
    logic [1:0]  cause;
    logic        evolve;
  } vec_t;

  vec_t vecs[13];

  life_ctrl #(.TICK_DIV(4), .GEN_W(16)) u_dut_a (
    .clk(clk), .flopreset(flopreset), .start(start), .run(run), .step(step),
    .shift_seed(seed), .grid_evo(a_evo), .gridOut(a_grid), .gen_count(a_gen),
    .running(a_running), .halted(a_halted), .halt_cause(a_cause), .evolve(a_evolve)
  );
  datapath u_dp_a (.grid_in(a_grid), .grid_out(a_evo));

  life_ctrl #(.TICK_DIV(1), .GEN_W(16)) u_dut_b (
    .clk(clk), .flopreset(flopreset), .start(start), .run(run), .step(step),
    .shift_seed(seed), .grid_evo(b_evo), .gridOut(b_grid), .gen_count(b_gen),
    .running(b_running), .halted(b_halted), .halt_cause(b_cause), .evolve(b_evolve)
  );
  datapath u_dp_b (.grid_in(b_grid), .grid_out(b_evo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // flags packed as {running, halted, cause[1:0], evolve}
  task automatic check_a(input string tag, input logic [63:0] grid, input logic [15:0] gen,
                         input logic [4:0] flags);
    check({tag, " a.grid"}, a_grid, grid);
    check({tag, " a.gen"}, {48'd0, a_gen}, {48'd0, gen});
    check({tag, " a.flags"}, {59'd0, a_running, a_halted, a_cause, a_evolve}, {59'd0, flags});
  endtask

  task automatic check_b(input string tag, input logic [63:0] grid, input logic [15:0] gen,
                         input logic [4:0] flags);
    check({tag, " b.grid"}, b_grid, grid);
    check({tag, " b.gen"}, {48'd0, b_gen}, {48'd0, gen});
    check({tag, " b.flags"}, {59'd0, b_running, b_halted, b_cause, b_evolve}, {59'd0, flags});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    flopreset = 1'b0;
    start = 1'b0;
    run = 1'b0;
    step = 1'b0;
    seed = '0;

    //           start run  step  seed     grid     gen    run  hlt  cause  evo
    vecs[0]  = '{1'b1, 1'b0, 1'b0, BLINKER, BLINKER, 16'd0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, BLINKER, BLINKER, 16'd0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, BLINKER, VERT,    16'd1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, BLINKER, VERT,    16'd1, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, BLINKER, BLINKER, 16'd2, 1'b0, 1'b1, 2'b11, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, BLINKER, BLINKER, 16'd2, 1'b0, 1'b1, 2'b11, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, BLINKER, BLINKER, 16'd2, 1'b0, 1'b1, 2'b11, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, SINGLE,  SINGLE,  16'd0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, SINGLE,  SINGLE,  16'd0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, SINGLE,  64'd0,   16'd1, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, SINGLE,  64'd0,   16'd1, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, SINGLE,  64'd0,   16'd1, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, SINGLE,  64'd0,   16'd1, 1'b0, 1'b1, 2'b01, 1'b0};

    repeat (3) cyc();
    check_a("reset", 64'd0, 16'd0, 5'b00000);
    check_b("reset", 64'd0, 16'd0, 5'b00000);
    flopreset = 1'b1;
    repeat (2) cyc();

    for (int i = 0; i < 13; i++) begin
      start = vecs[i].start;
      run   = vecs[i].run;
      step  = vecs[i].step;
      seed  = vecs[i].seed;
      cyc();
      $display("vec %0d: start=%b run=%b step=%b grid=%h gen=%0d cause=%b evolve=%b",
               i, start, run, step, a_grid, a_gen, a_cause, a_evolve);
      check_a($sformatf("vec%0d", i), vecs[i].grid, vecs[i].gen,
              {vecs[i].running, vecs[i].halted, vecs[i].cause, vecs[i].evolve});
    end

    // Block in RUN at TICK_DIV=4: first evolution lands 4 edges after entry.
    start = 1'b1; run = 1'b1; step = 1'b0; seed = BLOCK;
    cyc();
    $display("block load: grid=%h running=%b", a_grid, a_running);
    check_a("block load", BLOCK, 16'd0, 5'b10000);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      $display("block wait %0d: gen=%0d evolve=%b", k, a_gen, a_evolve);
      check_a($sformatf("block wait%0d", k), BLOCK, 16'd0, 5'b10000);
    end
    cyc();
    $display("block tick: gen=%0d halted=%b cause=%b", a_gen, a_halted, a_cause);
    check_a("block halt", BLOCK, 16'd1, 5'b01101);

    // Glider at TICK_DIV=1: evolves every cycle.
    seed = GLIDER; start = 1'b1;
    cyc();
    $display("glider load: grid=%h", b_grid);
    check_b("glider load", GLIDER, 16'd0, 5'b10000);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      $display("glider gen %0d: grid=%h evolve=%b", k, b_grid, b_evolve);
      check($sformatf("glider%0d b.gen", k), {48'd0, b_gen}, 64'(k));
      check($sformatf("glider%0d b.evolve", k), {63'd0, b_evolve}, 64'd1);
    end
    check("glider4 b.grid", b_grid, GLIDER4);

    // Start mid-run beats the tick that is due in the same cycle.
    seed = BLINKER; start = 1'b1;
    cyc();
    $display("midrun load: grid=%h gen=%0d evolve=%b", b_grid, b_gen, b_evolve);
    check_b("midrun load", BLINKER, 16'd0, 5'b10000);
    start = 1'b0;
    cyc();
    $display("midrun evolve: grid=%h gen=%0d", b_grid, b_gen);
    check_b("midrun evolve", VERT, 16'd1, 5'b10001);

    // Asynchronous reset mid-RUN, away from any clock edge.
    #2;
    flopreset = 1'b0;
    #1;
    $display("async reset: b.grid=%h b.running=%b", b_grid, b_running);
    check_a("async rst", 64'd0, 16'd0, 5'b00000);
    check_b("async rst", 64'd0, 16'd0, 5'b00000);

    // Start held high through reset release must not load.
    start = 1'b1; seed = BLOCK;
    @(posedge clk);
    #3;
    flopreset = 1'b1;
    repeat (3) cyc();
    $display("start held through reset: b.grid=%h b.running=%b", b_grid, b_running);
    check_b("held start", 64'd0, 16'd0, 5'b00000);
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    $display("fresh start: b.grid=%h b.running=%b", b_grid, b_running);
    check_b("fresh start", BLOCK, 16'd0, 5'b10000);
    start = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/life_ctrl.md
# life_ctrl

Generation controller for the 8x8 Game of Life core. It owns the 64-bit grid register and loads it from the seed. It sequences the combinational evolve datapath at a programmable rate, or single-steps it, and counts generations. It halts automatically on extinction, a still life or a period-2 oscillator. It sits between the user controls and the `datapath` instance, and `gridOut` drives the display.

## Interface
- `TICK_DIV`, 25_000_000: clock cycles per generation in RUN; must be >= 1.
- `GEN_W`, 16: generation counter width.

- `clk`  in  1  system clock, rising edge.
- `flopreset`  in  1  asynchronous, active-low reset.
- `start`  in  1  load request; rising-edge detected internally.
- `run`  in  1  level; 1 = free-run, 0 = pause.
- `step`  in  1  single-generation request; rising-edge detected internally.
- `shift_seed`  in  64  seed pattern, sampled on load.
- `grid_evo`  in  64  next generation from `datapath`, combinational from `gridOut`.
- `gridOut`  out  64  current grid; bit index = row*8+col.
- `gen_count`  out  GEN_W  generations since last load; saturates at all-ones.
- `running`  out  1  state == RUN.
- `halted`  out  1  state == HALT.
- `halt_cause`  out  2  00 none, 01 extinct, 10 still, 11 period-2.
- `evolve`  out  1  one-cycle pulse, high the cycle after `gridOut` takes `grid_evo`.

## Operation
- Reset values: `gridOut`=0, `gen_count`=0, `halt_cause`=00, `evolve`=0. State is IDLE, the prescaler is 0 and `prev_valid`=0. The edge detectors' previous-value registers are 0.
- States: IDLE, PAUSE, RUN, HALT.
- Load: on a start rise in any state:
  - `gridOut`<=`shift_seed`, `gen_count`<=0, `halt_cause`<=00, prescaler<=0, `prev_valid`<=0.
  - Next state is RUN if `run`=1, else PAUSE.
- IDLE: only a start rise has effect.
- PAUSE:
  - A step rise performs one evolution.
  - `run`=1 moves to RUN with the prescaler cleared.
- RUN:
  - The prescaler counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it wraps to 0 and one evolution is performed.
  - `run`=0 moves to PAUSE. An evolution due that same cycle still happens.
  - Step rises are ignored.
- Evolution, performed in one edge:
  - `grid_prev`<=`gridOut`, `gridOut`<=`grid_evo`, `prev_valid`<=1.
  - `gen_count` increments, saturating.
  - `evolve` pulses.
- Halt check, evaluated on every evolution using pre-update values; priority order:
  - `grid_evo`==0 gives extinct.
  - `grid_evo`==`gridOut` gives still.
  - `prev_valid` && `grid_evo`==`grid_prev` gives period-2.
  - On any match, the evolution still commits, `halt_cause` is set and the next state is HALT.
- HALT: the grid is frozen. `run` and `step` are ignored. Only a start rise leaves HALT.
- Simultaneous events:
  - A start rise beats step and tick in the same cycle: the load happens, no evolution.
  - A step rise and `run` 0->1 in the same PAUSE cycle: the step evolves and the state moves to RUN.
- Reset mid-operation returns to reset values immediately, asynchronously.

## Timing
- Load latency: start rises before edge k, so `gridOut`=seed after edge k.
- Step latency: `gridOut` updates at the first edge that sees the rise. `evolve` is high for the following cycle.
- RUN cadence: the first evolution comes TICK_DIV edges after entering RUN, then one every TICK_DIV edges. TICK_DIV=1 evolves every cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `grid_evo` must settle within one clock period.

## Structure
- Package `life_pkg`:
  - `GRID_W`=64.
  - `state_t` enum {IDLE, PAUSE, RUN, HALT}.
  - `halt_cause_t` codes NONE/EXTINCT/STILL/OSC2.
- Sub-module `tick_prescaler`:
  - Parameter TICK_DIV; inputs `clk`, `flopreset`, `clear`, `enable`; output `tick`.
  - `tick` is a one-cycle pulse at terminal count.
- `life_ctrl` holds the FSM, the grid and `grid_prev` registers, the edge detectors, the counter and the halt compare logic.
- The bench instantiates the real `datapath` to supply `grid_evo`.

## Test plan
- Reset, then pulse start with seed 0x0000_0000_1C00_0000 (horizontal blinker), `run`=0:
  - `gridOut`=0x0000_0000_1C00_0000, `gen_count`=0, state PAUSE.
- Step twice:
  - `gridOut`=0x0000_0008_0808_0000, then 0x0000_0000_1C00_0000.
  - Halts with `halt_cause`=11 on the second step, `gen_count`=2.
- Seed 0x0000_0018_1800_0000 (block), `run`=1, TICK_DIV=4:
  - First evolution 4 cycles after entering RUN.
  - Halts with cause 10, `gen_count`=1, `gridOut` unchanged.
- Seed 0x0000_0000_0800_0000 (single cell), step:
  - `gridOut`=0, cause 01, `halted`=1.
  - A further step has no effect.
- Glider seed, RUN with TICK_DIV=1:
  - `evolve` pulses every cycle.
  - Assert start mid-run with a new seed: the load wins, `gen_count`=0, no evolution that cycle.
- Assert `flopreset`=0 asynchronously mid-RUN: all outputs go to 0 before the next edge. Hold start high across the release of reset: no load occurs until start falls and rises again.
